case_1_sdiv_5s_5s_5_seq: RTL and testbench
==========================================

// Module: case_1_sdiv_5s_5s_5_seq
// PURPOSE
// - Sequential signed integer divider; the inverse operator of the case_1 signed 5x5 multiplier.
// - Computes din0 / din1 and din0 % din1 with C semantics:
//   - quotient truncates toward zero;
//   - remainder takes the dividend's sign.
// - Radix-2 restoring, one quotient bit per cycle, start/done handshake.
// - Instantiated by the case_1 datapath wherever the schedule needs a divide.
// PARAMETERS
// - din0_WIDTH  5  dividend width (signed); also the quotient width and the iteration count
// - din1_WIDTH  5  divisor width (signed); also the remainder width. Must be <= din0_WIDTH
// - dout_WIDTH  5  quotient output width. Must equal din0_WIDTH
// PORTS
// - ap_clk       in   1             clock; all state updates on the rising edge
// - ap_rst       in   1             reset, asynchronous, active-high
// - start        in   1             request; sampled only in IDLE
// - din0         in   din0_WIDTH    signed dividend; sampled with start
// - din1         in   din1_WIDTH    signed divisor; sampled with start
// - busy         out  1             high from the start-accept edge until done is asserted
// - done         out  1             one-cycle pulse; results valid while done=1
// - dout         out  dout_WIDTH    signed quotient; held until the next done
// - rem          out  din1_WIDTH    signed remainder; held until the next done
// - div_by_zero  out  1             set with done when din1 == 0; held until the next done
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE;
//   - busy, done, dout, rem, div_by_zero, iteration counter and internal registers all 0.
// - FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
// - IDLE:
//   - on start=1 at edge k, latch |din0|, |din1|, sign(din0), sign(din1) and the zero flag;
//   - clear partial remainder; counter = din0_WIDTH-1; busy=1; go to CALC.
// - CALC, one edge per bit, MSB first:
//   - shift the remainder left, bringing in the next dividend bit;
//   - if remainder >= |divisor|, subtract it and set the quotient bit to 1, else set it to 0;
//   - when counter reaches 0, go to FIX; otherwise decrement the counter.
// - FIX, one edge:
//   - negate the quotient if sign(din0) XOR sign(din1);
//   - negate the remainder if sign(din0);
//   - register the results into dout and rem; set done=1, busy=0; go to DONE.
// - DONE: done=1 for exactly this one cycle; next edge clears done and returns to IDLE.
// - Latency:
//   - start sampled at edge k -> done=1 in the cycle after edge k+din0_WIDTH+1 (6 edges for defaults);
//   - latency is fixed and does not depend on the data.
// - Widths:
//   - magnitudes are held in din0_WIDTH+1 bits so that |MIN| is representable;
//   - results are truncated to the port widths (two's complement wrap).
// - Divide by zero: dout = all ones (-1), rem = din0 truncated to din1_WIDTH, div_by_zero=1.
// - Overflow MIN/-1: dout = MIN (wrapped), rem = 0, div_by_zero=0.
// - start while busy or in DONE: ignored, with no queuing and no effect on the operation in flight.
// - start held high continuously: a new operation is accepted on each return to IDLE.
// - Reset mid-operation: operation is aborted; no done pulse; outputs return to 0.
// - Inputs din0/din1 may change freely after the accept edge.
// TESTING
// - 13 / 4 -> dout=3, rem=1, dbz=0; done exactly 6 edges after the start edge, busy high for 6 cycles.
// - -13 / 4 -> dout=-3 (5'b11101), rem=-1 (5'b11111); 7 / -2 -> dout=-3, rem=1.
// - -16 / -1 -> dout=-16 (5'b10000), rem=0, dbz=0; -16 / 1 -> dout=-16, rem=0.
// - 9 / 0 -> dout=5'b11111, rem=9, dbz=1; the following 6 / 3 -> dout=2, rem=0, dbz cleared.
// - Start with 15 / 2, pulse start again with 1 / 1 in CALC -> single done, dout=7, rem=1;
//   the second request is not executed.
// - Start 12 / 5, assert ap_rst mid-CALC -> all outputs 0 immediately, no done;
//   after release, 12 / 5 -> dout=2, rem=2.
// - Sweep all 1024 (din0, din1) pairs back-to-back against C-model truncating division; zero mismatches.

Source files
------------

// File: rtl/case_1_sdiv_5s_5s_5_seq.sv
// ---------------------------------------------------------------------------
// case_1_sdiv_5s_5s_5_seq
//   Sequential signed divider (radix-2 restoring, one quotient bit per cycle).
//   Produces din0 / din1 (truncated toward zero) and din0 % din1 (sign of the
//   dividend), i.e. C semantics, behind a start/done handshake.
//
// Ports
//   ap_clk       in   clock, rising edge
//   ap_rst       in   asynchronous active-high reset
//   start        in   request, sampled only while idle
//   din0         in   signed dividend  [din0_WIDTH-1:0]
//   din1         in   signed divisor   [din1_WIDTH-1:0]
//   busy         out  high from the accept edge until done
//   done         out  one-cycle pulse, results valid while high
//   dout         out  signed quotient  [dout_WIDTH-1:0], held until next done
//   rem          out  signed remainder [din1_WIDTH-1:0], held until next done
//   div_by_zero  out  set with done when din1 == 0, held until next done
// ---------------------------------------------------------------------------
module case_1_sdiv_5s_5s_5_seq #(
    parameter int din0_WIDTH = 5,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    localparam int QW  = din0_WIDTH;
    localparam int RW  = din1_WIDTH;
    localparam int MW1 = din1_WIDTH + 1;
    localparam int CW  = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working registers
    logic [QW-1:0]  work;       // dividend magnitude shifting out, quotient shifting in
    logic [MW1-1:0] dsr_mag;    // divisor magnitude, one spare bit so |MIN| fits
    logic [RW-1:0]  prem;       // partial remainder, always < |divisor|
    logic           sign0;
    logic           sign1;
    logic           dsr_zero;
    logic [RW-1:0]  din0_lo;    // dividend truncated to remainder width (div-by-zero result)
    logic [CW-1:0]  cnt;

    // Combinational datapath
    logic [QW-1:0]  mag0;
    logic [RW-1:0]  mag1;
    logic [MW1-1:0] shifted;
    logic [MW1-1:0] diff;
    logic           ge;
    logic [QW-1:0]  q_fix;
    logic [RW-1:0]  r_fix;

    // The dividend magnitude is kept unsigned in din0_WIDTH bits: |MIN| = 2^(W-1)
    // fits there, which is equivalent to a W+1-bit signed magnitude.
    always_comb begin
        mag0 = din0;
        if (din0[QW-1]) begin
            mag0 = ~din0 + 1'b1;
        end
        mag1 = din1;
        if (din1[RW-1]) begin
            mag1 = ~din1 + 1'b1;
        end
    end

    // One restoring step: bring in the next dividend bit, trial-subtract.
    always_comb begin
        shifted = {prem, work[QW-1]};
        diff    = shifted - dsr_mag;
        ge      = (shifted >= dsr_mag);
    end

    // Sign correction of the magnitude results.
    always_comb begin
        q_fix = work;
        if (sign0 ^ sign1) begin
            q_fix = ~work + 1'b1;
        end
        r_fix = prem;
        if (sign0) begin
            r_fix = ~prem + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC, FIX: busy = 1'b1;
            DONE:      done = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            work        <= '0;
            dsr_mag     <= '0;
            prem        <= '0;
            sign0       <= 1'b0;
            sign1       <= 1'b0;
            dsr_zero    <= 1'b0;
            din0_lo     <= '0;
            cnt         <= '0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= mag0;
                        dsr_mag  <= {1'b0, mag1};
                        sign0    <= din0[QW-1];
                        sign1    <= din1[RW-1];
                        dsr_zero <= (din1 == '0);
                        din0_lo  <= din0[RW-1:0];
                        prem     <= '0;
                        cnt      <= CW'(din0_WIDTH - 1);
                    end
                end
                CALC: begin
                    // Remainder stays below |divisor| <= 2^RW, so RW bits hold it
                    // after either the subtract or the pass-through.
                    prem <= ge ? RW'(diff) : RW'(shifted);
                    work <= {work[QW-2:0], ge};
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (dsr_zero) begin
                        dout        <= '1;
                        rem         <= din0_lo;
                        div_by_zero <= 1'b1;
                    end else begin
                        dout        <= q_fix;
                        rem         <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_case_1_sdiv_5s_5s_5_seq.sv
module tb_case_1_sdiv_5s_5s_5_seq;

    logic       ap_clk;
    logic       ap_rst;
    logic       start;
    logic [4:0] din0;
    logic [4:0] din1;
    logic       busy;
    logic       done;
    logic [4:0] dout;
    logic [4:0] rem;
    logic       div_by_zero;

    int checks;
    int errors;
    int done_cnt;

    typedef struct {
        logic [4:0] q;
        logic [4:0] r;
        logic       z;
        string      name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] q;
        logic [4:0] r;
        logic       z;
        string      name;
    } vec_t;

    case_1_sdiv_5s_5s_5_seq #(
        .din0_WIDTH(5),
        .din1_WIDTH(5),
        .dout_WIDTH(5)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge ap_clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got dout=%b rem=%b dbz=%b expected no result",
                         dout, rem, div_by_zero);
            end else begin
                e = sb.pop_front();
                if (dout !== e.q || rem !== e.r || div_by_zero !== e.z) begin
                    errors++;
                    $display("FAIL %s: got dout=%b rem=%b dbz=%b expected dout=%b rem=%b dbz=%b",
                             e.name, dout, rem, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    end

    // C-semantics reference: SV int '/' and '%' truncate toward zero.
    function automatic void model(input logic [4:0] a, input logic [4:0] b,
                                  output logic [4:0] q, output logic [4:0] r,
                                  output logic z);
        int sa;
        int sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        if (sbv == 0) begin
            q = 5'b11111;
            r = a;
            z = 1'b1;
        end else begin
            q = 5'(sa / sbv);
            r = 5'(sa % sbv);
            z = 1'b0;
        end
    endfunction

    // Issue one operation, push its expectation, check latency, busy span and
    // the single-cycle done pulse.
    task automatic do_op(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] q, input logic [4:0] r,
                         input logic z, input string name);
        exp_t e;
        int   n;
        int   bcnt;
        @(negedge ap_clk);
        din0  = a;
        din1  = b;
        start = 1'b1;
        e.q = q; e.r = r; e.z = z; e.name = name;
        sb.push_back(e);
        @(posedge ap_clk);
        #1;
        start = 1'b0;
        din0  = ~a;
        din1  = ~b;
        n    = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge ap_clk);
            #1;
            n++;
            if (busy === 1'b1) bcnt++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 20 edges", name);
            void'(sb.pop_back());
        end else begin
            check({name, "_latency"}, n, 6);
            check({name, "_busy_cycles"}, bcnt, 6);
            @(posedge ap_clk);
            #1;
            check({name, "_done_pulse"}, {31'd0, done}, 0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        ap_rst   = 1'b1;
        start    = 1'b0;
        din0     = '0;
        din1     = '0;

        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_dout", {27'd0, dout}, 0);
        check("rst_rem",  {27'd0, rem}, 0);
        check("rst_dbz",  {31'd0, div_by_zero}, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        vecs[0] = '{5'd13,    5'd4,     5'd3,     5'd1,     1'b0, "13_div_4"};
        vecs[1] = '{5'b10011, 5'd4,     5'b11101, 5'b11111, 1'b0, "m13_div_4"};
        vecs[2] = '{5'd7,     5'b11110, 5'b11101, 5'd1,     1'b0, "7_div_m2"};
        vecs[3] = '{5'b10000, 5'b11111, 5'b10000, 5'd0,     1'b0, "min_div_m1"};
        vecs[4] = '{5'b10000, 5'd1,     5'b10000, 5'd0,     1'b0, "min_div_1"};
        vecs[5] = '{5'd9,     5'd0,     5'b11111, 5'd9,     1'b1, "9_div_0"};
        vecs[6] = '{5'd6,     5'd3,     5'd2,     5'd0,     1'b0, "6_div_3"};
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].name);
        end

        // Second start during CALC must be ignored.
        begin
            exp_t e;
            int   base;
            int   n;
            @(negedge ap_clk);
            din0 = 5'd15; din1 = 5'd2; start = 1'b1;
            e.q = 5'd7; e.r = 5'd1; e.z = 1'b0; e.name = "15_div_2_collide";
            sb.push_back(e);
            base = done_cnt;
            @(posedge ap_clk);
            #1;
            start = 1'b0;
            repeat (2) @(posedge ap_clk);
            @(negedge ap_clk);
            din0 = 5'd1; din1 = 5'd1; start = 1'b1;
            @(negedge ap_clk);
            start = 1'b0;
            n = 0;
            while (done_cnt == base && n < 20) begin
                @(posedge ap_clk);
                n++;
            end
            repeat (12) @(posedge ap_clk);
            #1;
            check("collide_single_done", done_cnt - base, 1);
            check("collide_idle_busy", {31'd0, busy}, 0);
        end

        // Reset in the middle of CALC aborts without a done pulse.
        begin
            int base;
            @(negedge ap_clk);
            din0 = 5'd12; din1 = 5'd5; start = 1'b1;
            @(posedge ap_clk);
            #1;
            start = 1'b0;
            repeat (2) @(posedge ap_clk);
            @(negedge ap_clk);
            base = done_cnt;
            ap_rst = 1'b1;
            #1;
            check("midrst_dout", {27'd0, dout}, 0);
            check("midrst_rem",  {27'd0, rem}, 0);
            check("midrst_dbz",  {31'd0, div_by_zero}, 0);
            check("midrst_busy", {31'd0, busy}, 0);
            repeat (2) @(posedge ap_clk);
            @(negedge ap_clk);
            ap_rst = 1'b0;
            repeat (10) @(posedge ap_clk);
            #1;
            check("midrst_no_done", done_cnt - base, 0);
            do_op(5'd12, 5'd5, 5'd2, 5'd2, 1'b0, "12_div_5_after_rst");
        end

        // Exhaustive sweep against the C-semantics reference.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                logic [4:0] q;
                logic [4:0] r;
                logic       z;
                model(5'(a), 5'(b), q, r, z);
                do_op(5'(a), 5'(b), q, r, z, "sweep");
            end
        end

        repeat (3) @(posedge ap_clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule
